// File: rtl/rs_dsp_pkg.sv
// Shared types and widths for the DSP38 MULTIPLY_ADD_SUB sequencer slice.
package rs_dsp_pkg;

    localparam int DSP_A_W = 20;
    localparam int DSP_B_W = 18;
    localparam int DSP_Z_W = 38;

    typedef struct packed {
        logic       subtract;
        logic       round;
        logic       saturate;
        logic       unsigned_a;
        logic       unsigned_b;
        logic [5:0] shift_right;
    } dsp_cfg_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_RESULT
    } seq_state_t;

endpackage

// File: rtl/rs_dsp_multadd_core.sv
// Behavioural stand-in for a DSP38 in MULTIPLY_ADD_SUB mode (no input/output regs).
// LOAD_ACC=1 restarts the accumulator with the current product.
module rs_dsp_multadd_core
    import rs_dsp_pkg::*;
#(
    parameter int ACC_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DSP_A_W-1:0] a,
    input  logic [DSP_B_W-1:0] b,
    input  logic               load_acc,
    input  dsp_cfg_t           cfg,
    output logic [DSP_Z_W-1:0] z
);

    localparam int ACC_W = 48;
    localparam logic signed [ACC_W-1:0] Z_MAX = ACC_W'({1'b0, {(DSP_Z_W-1){1'b1}}});
    localparam logic signed [ACC_W-1:0] Z_MIN = -Z_MAX - ACC_W'(1);

    logic signed [DSP_A_W:0]   a_ext;
    logic signed [DSP_B_W:0]   b_ext;
    logic signed [ACC_W-1:0]   prod;
    logic signed [ACC_W-1:0]   addend;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   rnd;
    logic signed [ACC_W-1:0]   shv;
    logic        [DSP_Z_W-1:0] z_raw;

    always_comb begin
        a_ext  = {(cfg.unsigned_a ? 1'b0 : a[DSP_A_W-1]), a};
        b_ext  = {(cfg.unsigned_b ? 1'b0 : b[DSP_B_W-1]), b};
        prod   = ACC_W'(a_ext) * ACC_W'(b_ext);
        addend = cfg.subtract ? -prod : prod;
        rnd    = acc;
        if (cfg.round && cfg.shift_right != 6'd0)
            rnd = acc + (ACC_W'(1) <<< (cfg.shift_right - 6'd1));
        shv    = rnd >>> cfg.shift_right;
        z_raw  = shv[DSP_Z_W-1:0];
        if (cfg.saturate && shv > Z_MAX) z_raw = Z_MAX[DSP_Z_W-1:0];
        if (cfg.saturate && shv < Z_MIN) z_raw = Z_MIN[DSP_Z_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         acc <= '0;
        else if (load_acc) acc <= addend;
        else               acc <= acc + addend;
    end

    // Extra Z stages model devices whose accumulator result appears later.
    generate
        if (ACC_LAT <= 1) begin : g_z_direct
            assign z = z_raw;
        end else begin : g_z_pipe
            logic [ACC_LAT-2:0][DSP_Z_W-1:0] z_q;
            always_ff @(posedge clk or posedge reset) begin
                if (reset) z_q <= '0;
                else begin
                    z_q[0] <= z_raw;
                    for (int i = 1; i < ACC_LAT - 1; i++) z_q[i] <= z_q[i-1];
                end
            end
            assign z = z_q[ACC_LAT-2];
        end
    endgenerate

endmodule

// File: rtl/rs_dsp_mac_sequencer.sv
// Job-level controller: turns a job descriptor plus an operand stream into one
// DSP38 dot product and returns it on a valid/ready result port.
module rs_dsp_mac_sequencer
    import rs_dsp_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int ACC_LAT = 1
) (
    input  logic               clk,
    input  logic               lreset,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [LEN_W-1:0]   job_len,
    input  logic [10:0]        job_cfg,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [DSP_A_W-1:0] op_a,
    input  logic [DSP_B_W-1:0] op_b,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DSP_Z_W-1:0] res_data,
    output logic [DSP_A_W-1:0] dsp_a,
    output logic [DSP_B_W-1:0] dsp_b,
    output logic               dsp_load_acc,
    output logic [2:0]         dsp_feedback,
    output logic [5:0]         dsp_acc_fir,
    output dsp_cfg_t           dsp_cfg,
    input  logic [DSP_Z_W-1:0] dsp_z
);

    localparam logic [1:0] LAT_LAST = 2'(ACC_LAT - 1);

    seq_state_t       state, state_nxt;
    logic [LEN_W-1:0] tap_cnt;
    logic [1:0]       lat_cnt;
    logic             first_tap;
    logic             lat_done;
    logic             op_fire;

    assign dsp_feedback = 3'd0;
    assign dsp_acc_fir  = 6'd0;
    assign lat_done     = (lat_cnt == LAT_LAST);
    assign op_fire      = (state == ST_ACCUM) && op_valid;

    always_ff @(posedge clk or negedge lreset) begin
        if (!lreset) begin
            state     <= ST_IDLE;
            tap_cnt   <= '0;
            lat_cnt   <= '0;
            first_tap <= 1'b0;
            dsp_cfg   <= '0;
            res_data  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: if (job_valid) begin
                    tap_cnt   <= job_len;
                    dsp_cfg   <= dsp_cfg_t'(job_cfg);
                    first_tap <= 1'b1;
                    lat_cnt   <= '0;
                    if (job_len == '0) res_data <= '0;
                end
                ST_ACCUM: if (op_valid) begin
                    tap_cnt   <= tap_cnt - LEN_W'(1);
                    first_tap <= 1'b0;
                end
                ST_DRAIN: begin
                    lat_cnt <= lat_cnt + 2'd1;
                    if (lat_done) res_data <= dsp_z;
                end
                default: ;
            endcase
        end
    end

    // Idle ACCUM cycles feed zero operands so the accumulator holds its value.
    always_comb begin
        state_nxt    = state;
        job_ready    = 1'b0;
        op_ready     = 1'b0;
        res_valid    = 1'b0;
        dsp_a        = '0;
        dsp_b        = '0;
        dsp_load_acc = 1'b0;
        case (state)
            ST_IDLE: begin
                job_ready = 1'b1;
                if (job_valid) state_nxt = (job_len == '0) ? ST_RESULT : ST_ACCUM;
            end
            ST_ACCUM: begin
                op_ready = 1'b1;
                if (op_fire) begin
                    dsp_a        = op_a;
                    dsp_b        = op_b;
                    dsp_load_acc = first_tap;
                    if (tap_cnt == LEN_W'(1)) state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: if (lat_done) state_nxt = ST_RESULT;
            ST_RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_rs_dsp_mac_sequencer.sv
// Directed bench: sequencer closed-loop with the behavioural DSP38 core.
module tb_rs_dsp_mac_sequencer;
    import rs_dsp_pkg::*;

    localparam int LEN_W   = 8;
    localparam int ACC_LAT = 1;

    logic               clk, lreset;
    logic               job_valid, job_ready;
    logic [LEN_W-1:0]   job_len;
    logic [10:0]        job_cfg;
    logic               op_valid, op_ready;
    logic [DSP_A_W-1:0] op_a;
    logic [DSP_B_W-1:0] op_b;
    logic               res_valid, res_ready;
    logic [DSP_Z_W-1:0] res_data;
    logic [DSP_A_W-1:0] dsp_a;
    logic [DSP_B_W-1:0] dsp_b;
    logic               dsp_load_acc;
    logic [2:0]         dsp_feedback;
    logic [5:0]         dsp_acc_fir;
    dsp_cfg_t           dsp_cfg;
    logic [DSP_Z_W-1:0] dsp_z;

    int vec, miscmp, la_cnt;

    rs_dsp_mac_sequencer #(.LEN_W(LEN_W), .ACC_LAT(ACC_LAT)) dut (
        .clk(clk), .lreset(lreset),
        .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len), .job_cfg(job_cfg),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_load_acc(dsp_load_acc),
        .dsp_feedback(dsp_feedback), .dsp_acc_fir(dsp_acc_fir),
        .dsp_cfg(dsp_cfg), .dsp_z(dsp_z)
    );

    rs_dsp_multadd_core #(.ACC_LAT(ACC_LAT)) u_dsp (
        .clk(clk), .reset(~lreset), .a(dsp_a), .b(dsp_b),
        .load_acc(dsp_load_acc), .cfg(dsp_cfg), .z(dsp_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (dsp_load_acc === 1'b1) la_cnt++;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic start_job(input logic [LEN_W-1:0] len, input logic [10:0] cfg, output bit ok);
        ok = 0;
        job_len = len; job_cfg = cfg; job_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (job_ready) ok = 1;
            tick();
            if (ok) break;
        end
        job_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [DSP_A_W-1:0] a, input logic [DSP_B_W-1:0] b,
                             input int gap, output logic la, output bit ok);
        ok = 0; la = 1'bx;
        op_a = a; op_b = b; op_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (op_ready) begin ok = 1; la = dsp_load_acc; end
            tick();
            if (ok) break;
        end
        op_valid = 1'b0; op_a = '0; op_b = '0;
        repeat (gap) tick();
    endtask

    task automatic get_result(output logic [DSP_Z_W-1:0] d, output bit ok);
        ok = 0; d = 'x;
        res_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1; d = res_data; end
            tick();
            if (ok) break;
        end
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        lreset = 1'b0;
        #1;
        vec++;
        if ({job_ready, op_ready, res_valid, dsp_load_acc} !== 4'b1000) begin
            miscmp++; $display("FAIL reset_ctl: got %b want 1000", {job_ready, op_ready, res_valid, dsp_load_acc});
        end
        vec++;
        if ({res_data, dsp_a, dsp_b, dsp_cfg, dsp_feedback, dsp_acc_fir} !== '0) begin
            miscmp++; $display("FAIL reset_data: res_data=%h dsp_a=%h dsp_b=%h cfg=%h want all 0", res_data, dsp_a, dsp_b, dsp_cfg);
        end
        repeat (2) tick();
        lreset = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_accum();
        bit ok; logic la; logic [DSP_Z_W-1:0] d;
        start_job(8'd4, 11'h7FF, ok);
        send_pair(20'd5, 18'd5, 0, la, ok);
        send_pair(20'd6, 18'd6, 0, la, ok);
        op_a = 20'd9; op_b = 18'd9; op_valid = 1'b1;
        #2 lreset = 1'b0;
        #1;
        vec++;
        if ({job_ready, op_ready, res_valid, dsp_load_acc} !== 4'b1000) begin
            miscmp++; $display("FAIL midrst_ctl: got %b want 1000", {job_ready, op_ready, res_valid, dsp_load_acc});
        end
        vec++;
        if ({res_data, dsp_a, dsp_b, dsp_cfg} !== '0) begin
            miscmp++; $display("FAIL midrst_data: res_data=%h dsp_a=%h dsp_b=%h cfg=%h want 0", res_data, dsp_a, dsp_b, dsp_cfg);
        end
        op_valid = 1'b0; op_a = '0; op_b = '0;
        #2 lreset = 1'b1;
        tick();
        start_job(8'd2, 11'h0, ok);
        send_pair(20'd3, 18'd4, 0, la, ok);
        send_pair(20'd5, 18'd6, 0, la, ok);
        get_result(d, ok);
        vec++;
        if (!ok || d !== 38'd42) begin
            miscmp++; $display("FAIL post_reset_job: got %0d (ok=%0d) want 42", d, ok);
        end
    endtask

    task automatic test_signed_gaps();
        bit ok; logic la0, la1, la2; logic [DSP_Z_W-1:0] d;
        start_job(8'd3, 11'h0, ok);
        la_cnt = 0;
        send_pair(20'd2, 18'd3, 2, la0, ok);
        send_pair(-20'sd4, 18'd5, 2, la1, ok);
        send_pair(20'd7, -18'sd1, 0, la2, ok);
        vec++;
        if ({la0, la1, la2} !== 3'b100 || la_cnt != 1) begin
            miscmp++; $display("FAIL load_acc_first: got %b cnt=%0d want 100 cnt=1", {la0, la1, la2}, la_cnt);
        end
        get_result(d, ok);
        vec++;
        if (!ok || d !== -38'sd21) begin
            miscmp++; $display("FAIL signed_dot: got %h want %h", d, -38'sd21);
        end
    endtask

    task automatic test_zero_len();
        bit ok; logic [DSP_Z_W-1:0] d;
        la_cnt = 0;
        start_job(8'd0, 11'h0, ok);
        @(negedge clk);
        vec++;
        if (res_valid !== 1'b1 || res_data !== '0) begin
            miscmp++; $display("FAIL zero_len_result: valid=%b data=%h want 1/0", res_valid, res_data);
        end
        tick();
        get_result(d, ok);
        vec++;
        if (la_cnt != 0) begin
            miscmp++; $display("FAIL zero_len_load: load_acc count %0d want 0", la_cnt);
        end
    endtask

    task automatic test_back_to_back();
        bit ok, seen, held_bad; logic la; logic [DSP_Z_W-1:0] d;
        start_job(8'd1, 11'h0, ok);
        send_pair(20'd2, 18'd3, 0, la, ok);
        job_len = 8'd1; job_cfg = 11'h0; job_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid) begin seen = 1; break; end
            tick();
        end
        vec++;
        if (!seen) begin miscmp++; $display("FAIL b2b_wait: res_valid never rose (got 0 want 1)"); end
        held_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (res_valid !== 1'b1 || res_data !== 38'd6 || job_ready !== 1'b0) held_bad = 1;
            tick(); @(negedge clk);
        end
        vec++;
        if (held_bad) begin
            miscmp++; $display("FAIL b2b_hold: valid=%b data=%0d job_ready=%b want 1/6/0", res_valid, res_data, job_ready);
        end
        res_ready = 1'b1;
        vec++;
        if (job_ready !== 1'b0) begin miscmp++; $display("FAIL b2b_hs_cycle: job_ready=%b want 0", job_ready); end
        tick(); res_ready = 1'b0;
        @(negedge clk);
        vec++;
        if (job_ready !== 1'b1 || res_valid !== 1'b0) begin
            miscmp++; $display("FAIL b2b_accept: job_ready=%b res_valid=%b want 1/0", job_ready, res_valid);
        end
        tick(); job_valid = 1'b0;
        @(negedge clk);
        vec++;
        if (op_ready !== 1'b1) begin miscmp++; $display("FAIL b2b_accum: op_ready=%b want 1", op_ready); end
        tick();
        send_pair(20'd7, 18'd8, 0, la, ok);
        get_result(d, ok);
        vec++;
        if (!ok || d !== 38'd56) begin miscmp++; $display("FAIL b2b_second: got %0d want 56", d); end
    endtask

    task automatic test_cfg_hold();
        localparam logic [10:0] CFG = 11'b1_0_0_0_0_000010;
        bit ok, bad; logic la; logic [DSP_Z_W-1:0] d;
        start_job(8'd2, CFG, ok);
        bad = 0;
        @(negedge clk); if (dsp_cfg !== CFG) bad = 1;
        tick();
        send_pair(20'd10, 18'd4, 0, la, ok);
        job_cfg = ~CFG;
        @(negedge clk); if (dsp_cfg !== CFG) bad = 1;
        tick();
        send_pair(20'd6, 18'd2, 0, la, ok);
        @(negedge clk); if (dsp_cfg !== CFG) bad = 1;
        tick();
        vec++;
        if (bad) begin miscmp++; $display("FAIL cfg_hold: dsp_cfg=%h want %h", dsp_cfg, CFG); end
        get_result(d, ok);
        job_cfg = '0;
        vec++;
        if (!ok || d !== -38'sd13) begin miscmp++; $display("FAIL sub_shift: got %h want %h", d, -38'sd13); end
    endtask

    task automatic test_max_len();
        int cyc; bit seen;
        op_a = 20'd1; op_b = 18'd1; op_valid = 1'b1;
        job_len = 8'd255; job_cfg = 11'b0_0_0_1_1_000000; job_valid = 1'b1;
        cyc = 0; seen = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            cyc++;
            if (res_valid) begin seen = 1; break; end
            tick();
            job_valid = 1'b0;
        end
        vec++;
        if (!seen || cyc != 1 + 255 + ACC_LAT + 1) begin
            miscmp++; $display("FAIL max_latency: got %0d cycles want %0d", cyc, 1 + 255 + ACC_LAT + 1);
        end
        vec++;
        if (res_data !== 38'd255) begin miscmp++; $display("FAIL max_result: got %0d want 255", res_data); end
        res_ready = 1'b1; tick(); res_ready = 1'b0;
        op_valid = 1'b0; job_valid = 1'b0;
        @(negedge clk);
        vec++;
        if (job_ready !== 1'b1) begin miscmp++; $display("FAIL max_idle: job_ready=%b want 1", job_ready); end
    endtask

    initial begin
        vec = 0; miscmp = 0; la_cnt = 0;
        job_valid = 0; job_len = '0; job_cfg = '0;
        op_valid = 0; op_a = '0; op_b = '0; res_ready = 0;
        test_reset();
        test_reset_mid_accum();
        test_signed_gaps();
        test_zero_len();
        test_back_to_back();
        test_cfg_hold();
        test_max_len();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule

// File: doc/rs_dsp_mac_sequencer.md
Name: rs_dsp_mac_sequencer

Overview:
- Job-level controller for one DSP38 instance configured as MULTIPLY_ADD_SUB with input and output registers disabled.
- Accepts a job descriptor (tap count plus arithmetic options) and an operand-pair stream with valid/ready handshake.
- Drives the DSP38 A/B/LOAD_ACC/option pins so that each job yields one dot product, then returns it on a result valid/ready port.
- Sits between a FIR/matrix front-end and the DSP primitive wrapper.

Parameters:
- LEN_W, 8, width of the job tap count; max taps = 2^LEN_W-1.
- ACC_LAT, 1, cycles from the last LOAD_ACC/operand edge until Z reflects that operand; legal range 1..3.

Ports:
- clk  in  1  single clock; also drives the DSP38 CLK.
- lreset  in  1  asynchronous active-low reset, synchronously deasserted upstream; also drives the DSP38 RESET after inversion.
- job_valid  in  1  job descriptor valid.
- job_ready  out  1  sequencer can accept a job.
- job_len  in  LEN_W  tap count; 0 is legal.
- job_cfg  in  11  {subtract, round, saturate, unsigned_a, unsigned_b, shift_right[5:0]}.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  operand pair accepted this cycle when op_valid=1.
- op_a  in  20  multiplicand.
- op_b  in  18  multiplier.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_data  out  38  dot-product result.
- dsp_a  out  20  to DSP38 A.
- dsp_b  out  18  to DSP38 B.
- dsp_load_acc  out  1  to DSP38 LOAD_ACC.
- dsp_feedback  out  3  to DSP38 FEEDBACK; constant 0.
- dsp_acc_fir  out  6  to DSP38 ACC_FIR; constant 0.
- dsp_cfg  out  11  to DSP38 SUBTRACT/ROUND/SATURATE/UNSIGNED_A/UNSIGNED_B/SHIFT_RIGHT; latched job_cfg.
- dsp_z  in  38  from DSP38 Z.

Behaviour:
- Reset (lreset=0, asynchronous) forces the following; an in-flight job is discarded with no partial result:
  - state=IDLE, job_ready=1, op_ready=0, res_valid=0, res_data=0.
  - dsp_a=0, dsp_b=0, dsp_load_acc=0, dsp_cfg=0, tap counter=0.
- States are IDLE, ACCUM, DRAIN, RESULT.
- IDLE:
  - job_ready=1.
  - On job_valid: latch job_len into the remaining-tap counter and job_cfg into dsp_cfg.
  - Next state is ACCUM if job_len>0.
  - If job_len=0, next state is RESULT with res_data=0 and no DSP activity.
- ACCUM:
  - op_ready=1, job_ready=0.
  - On each op handshake: dsp_a=op_a and dsp_b=op_b combinationally.
  - dsp_load_acc=1 on the first accepted pair of the job only, 0 on later pairs; the counter decrements.
  - Cycles without a handshake drive dsp_a=dsp_b=0 and dsp_load_acc=0, so the accumulator adds zero and holds.
  - The handshake that brings the counter to 0 moves the FSM to DRAIN.
- DRAIN:
  - op_ready=0; operands forced to 0.
  - Waits ACC_LAT cycles (counter), then captures dsp_z into res_data and moves to RESULT.
- RESULT:
  - res_valid=1; res_data held stable until res_valid&&res_ready.
  - On that handshake: res_valid=0 and the FSM returns to IDLE.
  - job_ready=0 while in RESULT, so no job overlaps an unconsumed result.
- Throughput: a job of N taps with no stalls takes 1 (accept) + N + ACC_LAT + 1 (result) cycles minimum.
- dsp_cfg is stable for the whole job; a change on job_cfg mid-job is ignored.
- job_valid is ignored outside IDLE.
- op_valid is ignored outside ACCUM; a pair presented outside ACCUM is not consumed.
- Saturation, rounding and shift are performed inside the DSP; the sequencer passes dsp_z unmodified.

Decomposition:
- Shared package rs_dsp_pkg holds:
  - typedef dsp_cfg_t as the 11-bit packed struct with the field order above.
  - constants DSP_A_W=20, DSP_B_W=18, DSP_Z_W=38.
  - the enum for the sequencer state.
- Natural sub-module: rs_dsp_multadd_core, a thin DSP38 MULTIPLY_ADD_SUB instance taking dsp_cfg_t; used by the bench and the top level. The sequencer itself stays a single module.

Test Plan:
- Reset mid-ACCUM (lreset low after 2 of 4 taps) -> all outputs at reset values the same cycle; next job of 2 taps {(3,4),(5,6)} -> res_data=42.
- Job len=3, signed, pairs (2,3),(-4,5),(7,-1) with op_valid gaps of 2 cycles between pairs -> dsp_load_acc high only on the first pair, res_data=-21 sign-extended to 38 bits.
- Job len=0 -> res_valid one cycle after job handshake, res_data=0, dsp_load_acc never asserted.
- Back-to-back jobs with res_ready held low 5 cycles -> res_data stable, job_ready=0 throughout; the second job is accepted only in the cycle after the result handshake.
- Job with subtract=1, shift_right=2: cfg visible on dsp_cfg for the full job, unchanged when job_cfg toggles mid-job; a behavioural DSP model result matches res_data.
- Max length 255 taps of (1,1), unsigned -> res_data=255; total latency=1+255+ACC_LAT+1 cycles with op_valid held high.
